// File: rtl/apb_slave_regfile.sv
// APB3 completer backed by a word-addressed register file, with a fixed
// number of wait states per access and slverr on out-of-range or misaligned addresses.
module apb_slave_regfile #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = {ADDR_WIDTH{1'b0}},
  parameter int                    WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel,
  input  logic                  enable,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  slverr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                state_r;
  logic [3:0]            wcnt_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [ADDR_WIDTH-1:0] off_s;
  logic [IDX_W-1:0]      idx_s;
  logic                  err_s;
  logic                  ready_s;

  // Address decode: offset from the base, word index and error flag
  always_comb begin
    off_s = addr - BASE_ADDR;
    idx_s = off_s[IDX_W+1:2];
    err_s = (addr < BASE_ADDR)
          | (off_s >= ADDR_WIDTH'(DEPTH * 4))
          | (addr[1:0] != 2'b00);
  end

  // Response outputs; addr/write/wdata are used live at completion, never latched
  always_comb begin
    ready_s = (state_r == ACCESS) && (wcnt_r == 4'd0) && sel && enable;
    ready   = ready_s;
    slverr  = ready_s & err_s;
    if (ready_s && !write && !err_s) begin
      rdata = mem_r[idx_s];
    end else begin
      rdata = {DATA_WIDTH{1'b0}};
    end
  end

  // Transfer FSM, wait-state counter and register file update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      wcnt_r  <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          // sel&enable without a setup phase is ignored
          if (sel && !enable) begin
            state_r <= ACCESS;
            wcnt_r  <= 4'(WAIT_STATES);
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (!sel) begin
            state_r <= IDLE;
          end else if (!enable) begin
            state_r <= ACCESS;
          end else if (wcnt_r != 4'd0) begin
            wcnt_r <= wcnt_r - 4'd1;
          end else begin
            state_r <= IDLE;
            if (write && !err_s) begin
              mem_r[idx_s] <= wdata;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          wcnt_r  <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: three builds (defaults, zero-wait,
// BASE_ADDR=0x1000) driven from one vector table plus hand-written corner sequences.
module tb_apb_slave_regfile;

  logic        clk;
  logic        rst_n;
  logic        sel_v    [3];
  logic        enable_v [3];
  logic        write_v  [3];
  logic [31:0] addr_v   [3];
  logic [31:0] wdata_v  [3];
  logic        ready_v  [3];
  logic        slverr_v [3];
  logic [31:0] rdata_v  [3];

  int total;
  int bad;

  apb_slave_regfile u_dflt (
    .clk(clk), .rst_n(rst_n), .sel(sel_v[0]), .enable(enable_v[0]), .write(write_v[0]),
    .addr(addr_v[0]), .wdata(wdata_v[0]), .ready(ready_v[0]), .slverr(slverr_v[0]),
    .rdata(rdata_v[0]));

  apb_slave_regfile #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .sel(sel_v[1]), .enable(enable_v[1]), .write(write_v[1]),
    .addr(addr_v[1]), .wdata(wdata_v[1]), .ready(ready_v[1]), .slverr(slverr_v[1]),
    .rdata(rdata_v[1]));

  apb_slave_regfile #(.BASE_ADDR(32'h0000_1000)) u_base (
    .clk(clk), .rst_n(rst_n), .sel(sel_v[2]), .enable(enable_v[2]), .write(write_v[2]),
    .addr(addr_v[2]), .wdata(wdata_v[2]), .ready(ready_v[2]), .slverr(slverr_v[2]),
    .rdata(rdata_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          d;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    int          ws;
    logic        eerr;
    logic [31:0] erd;
    logic        b2b;
    string       nm;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle(input int d);
    @(posedge clk); #1;
    sel_v[d]    = 1'b0;
    enable_v[d] = 1'b0;
  endtask

  // Setup + access phase; returns at the negedge where ready is observed high
  task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input int ws, input logic eerr, input logic [31:0] erd, input string nm);
    int cyc;
    @(posedge clk); #1;
    sel_v[d] = 1'b1; enable_v[d] = 1'b0; write_v[d] = wr; addr_v[d] = a; wdata_v[d] = wd;
    @(negedge clk);
    chk({nm, "_setup_ready"}, 32'(ready_v[d]), 32'd0);
    @(posedge clk); #1;
    enable_v[d] = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!ready_v[d] && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    chk({nm, "_ready"}, 32'(ready_v[d]), 32'd1);
    chk({nm, "_waits"}, 32'(cyc), 32'(ws));
    chk({nm, "_slverr"}, 32'(slverr_v[d]), 32'(eerr));
    chk({nm, "_rdata"}, rdata_v[d], erd);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 3; i++) begin
      sel_v[i] = 1'b0; enable_v[i] = 1'b0; write_v[i] = 1'b0;
      addr_v[i] = 32'd0; wdata_v[i] = 32'd0;
    end

    vecs[0]  = '{0, 1'b1, 32'h08, 32'hDEADBEEF, 2, 1'b0, 32'h0,        1'b0, "d_wr08"};
    vecs[1]  = '{0, 1'b0, 32'h08, 32'h0,        2, 1'b0, 32'hDEADBEEF, 1'b0, "d_rd08"};
    vecs[2]  = '{0, 1'b0, 32'h40, 32'h0,        2, 1'b1, 32'h0,        1'b0, "d_rd40_range"};
    vecs[3]  = '{0, 1'b1, 32'h06, 32'h12345678, 2, 1'b1, 32'h0,        1'b0, "d_wr06_misal"};
    vecs[4]  = '{0, 1'b0, 32'h04, 32'h0,        2, 1'b0, 32'h0,        1'b0, "d_rd04"};
    vecs[5]  = '{0, 1'b0, 32'h3C, 32'h0,        2, 1'b0, 32'h0,        1'b0, "d_rd3c"};
    vecs[6]  = '{1, 1'b1, 32'h00, 32'h1,        0, 1'b0, 32'h0,        1'b1, "z_wr00"};
    vecs[7]  = '{1, 1'b1, 32'h3C, 32'hF,        0, 1'b0, 32'h0,        1'b1, "z_wr3c"};
    vecs[8]  = '{1, 1'b0, 32'h00, 32'h0,        0, 1'b0, 32'h1,        1'b1, "z_rd00"};
    vecs[9]  = '{1, 1'b0, 32'h3C, 32'h0,        0, 1'b0, 32'hF,        1'b0, "z_rd3c"};
    vecs[10] = '{2, 1'b1, 32'h1004, 32'h55,     2, 1'b0, 32'h0,        1'b0, "b_wr1004"};
    vecs[11] = '{2, 1'b0, 32'h1004, 32'h0,      2, 1'b0, 32'h55,       1'b0, "b_rd1004"};
    vecs[12] = '{2, 1'b0, 32'h0FFC, 32'h0,      2, 1'b1, 32'h0,        1'b0, "b_rd0ffc"};
    vecs[13] = '{2, 1'b0, 32'h1040, 32'h0,      2, 1'b1, 32'h0,        1'b0, "b_rd1040"};
    vecs[14] = '{2, 1'b1, 32'h1001, 32'h99,     2, 1'b1, 32'h0,        1'b0, "b_wr1001"};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(ready_v[0]), 32'd0);
    chk("rst_slverr", 32'(slverr_v[0]), 32'd0);
    chk("rst_rdata", rdata_v[0], 32'd0);

    for (int i = 0; i < 15; i++) begin
      xfer(vecs[i].d, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].ws,
           vecs[i].eerr, vecs[i].erd, vecs[i].nm);
      if (!vecs[i].b2b) idle(vecs[i].d);
    end
    xfer(2, 1'b0, 32'h1000, 32'h0, 2, 1'b0, 32'h0, "b_rd1000_nocorrupt");
    idle(2);

    // Reset during the wait of a write to 0x10
    @(posedge clk); #1;
    sel_v[0] = 1'b1; enable_v[0] = 1'b0; write_v[0] = 1'b1;
    addr_v[0] = 32'h10; wdata_v[0] = 32'hA5A5A5A5;
    @(posedge clk); #1 enable_v[0] = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_ready_in_rst", 32'(ready_v[0]), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rstmid_ready_after", 32'(ready_v[0]), 32'd0);
    end
    idle(0);
    xfer(0, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h0, "rstmid_rd10");
    idle(0);
    xfer(0, 1'b0, 32'h08, 32'h0, 2, 1'b0, 32'h0, "rstmid_rd08_cleared");
    idle(0);
    xfer(1, 1'b0, 32'h3C, 32'h0, 0, 1'b0, 32'h0, "rstmid_z_rd3c_cleared");
    idle(1);

    // Abort: sel dropped during the wait of a write to 0x0C
    @(posedge clk); #1;
    sel_v[0] = 1'b1; enable_v[0] = 1'b0; write_v[0] = 1'b1;
    addr_v[0] = 32'h0C; wdata_v[0] = 32'h1234;
    @(posedge clk); #1 enable_v[0] = 1'b1;
    @(negedge clk);
    chk("abort_wait1_ready", 32'(ready_v[0]), 32'd0);
    @(posedge clk); #1 sel_v[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_ready", 32'(ready_v[0]), 32'd0);
    end
    // sel&enable straight from IDLE, no setup phase
    @(posedge clk); #1 sel_v[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("noset_ready", 32'(ready_v[0]), 32'd0);
    end
    idle(0);
    xfer(0, 1'b0, 32'h0C, 32'h0, 2, 1'b0, 32'h0, "abort_rd0c");
    idle(0);

    // Requester stalls with enable low in the access phase: wait count is held
    @(posedge clk); #1;
    sel_v[0] = 1'b1; enable_v[0] = 1'b0; write_v[0] = 1'b1;
    addr_v[0] = 32'h14; wdata_v[0] = 32'h77;
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_ready", 32'(ready_v[0]), 32'd0);
    end
    @(posedge clk); #1 enable_v[0] = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_wait_ready", 32'(ready_v[0]), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("stall_done_ready", 32'(ready_v[0]), 32'd1);
    idle(0);
    xfer(0, 1'b0, 32'h14, 32'h0, 2, 1'b0, 32'h77, "stall_rd14");
    idle(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
